rv32_mc_ctrl: RTL and testbench



---
 rtl/rv32_mc_pkg.sv | 102 ++++++++++
 rtl/rv32_alu_op_decode.sv | 60 ++++++
 rtl/rv32_mc_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_rv32_mc_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mc_pkg.sv
// rtl/rv32_mc_pkg.sv - shared encodings for the RV32I multicycle control FSM
package rv32_mc_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b1000;
    localparam logic [3:0] ALU_SUB  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_OR   = 4'b0111;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0010;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_BEQ  = 4'b1101;
    localparam logic [3:0] ALU_BNE  = 4'b1111;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Datapath mux selects
    localparam logic [1:0] SRC_A_RS1   = 2'd0;
    localparam logic [1:0] SRC_A_PC    = 2'd1;
    localparam logic [1:0] SRC_A_OLDPC = 2'd2;
    localparam logic [1:0] SRC_A_ZERO  = 2'd3;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic       ADDR_PC     = 1'b0;
    localparam logic       ADDR_ALUOUT = 1'b1;
    localparam logic       PC_SRC_ALU    = 1'b0;
    localparam logic       PC_SRC_ALUOUT = 1'b1;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    // FSM states
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_ECALL   = 2'd2;
    localparam logic [1:0] CAUSE_MEM_TO  = 2'd3;

    // Register/immediate ALU op from funct3; alt selects SUB/SRA
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    // Branch outcome: BEQ/BNE look at the flag, the compare branches at the result LSB
    function automatic logic branch_taken(input logic [2:0] f3, input logic flag, input logic lsb);
        logic taken;
        case (f3)
            3'b000, 3'b001: taken = flag;
            3'b100, 3'b110: taken = lsb;
            3'b101, 3'b111: taken = ~lsb;
            default:        taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/rv32_alu_op_decode.sv
// rtl/rv32_alu_op_decode.sv - opcode/funct to ALU code and illegal-instruction flag
module rv32_alu_op_decode
    import rv32_mc_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_cntrl_o,
    output logic       illegal_o
);

    // Pure decode; SYSTEM is only screened on funct fields, the caller checks the rest
    always_comb begin
        alu_cntrl_o = ALU_ADDU;
        illegal_o   = 1'b0;
        case (opcode_i)
            OPC_OP: begin
                alu_cntrl_o = alu_from_funct3(funct3_i, funct7_i[5]);
                if (funct7_i == F7_ALT) begin
                    illegal_o = !(funct3_i == 3'b000 || funct3_i == 3'b101);
                end else begin
                    illegal_o = (funct7_i != F7_BASE);
                end
            end
            OPC_OPIMM: begin
                alu_cntrl_o = alu_from_funct3(funct3_i, (funct3_i == 3'b101) && funct7_i[5]);
                if (funct3_i == 3'b001) begin
                    illegal_o = (funct7_i != F7_BASE);
                end else if (funct3_i == 3'b101) begin
                    illegal_o = !(funct7_i == F7_BASE || funct7_i == F7_ALT);
                end
            end
            OPC_LUI, OPC_AUIPC: alu_cntrl_o = ALU_ADD;
            OPC_JAL:            alu_cntrl_o = ALU_ADDU;
            OPC_JALR: begin
                alu_cntrl_o = ALU_ADD;
                illegal_o   = (funct3_i != 3'b000);
            end
            OPC_BRANCH: begin
                case (funct3_i)
                    3'b000:         alu_cntrl_o = ALU_BEQ;
                    3'b001:         alu_cntrl_o = ALU_BNE;
                    3'b100, 3'b101: alu_cntrl_o = ALU_SLT;
                    3'b110, 3'b111: alu_cntrl_o = ALU_SLTU;
                    default:        illegal_o   = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                illegal_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
            end
            OPC_STORE: begin
                illegal_o = (funct3_i[2] == 1'b1) || (funct3_i == 3'b011);
            end
            OPC_FENCE:  illegal_o = (funct3_i != 3'b000);
            OPC_SYSTEM: illegal_o = (funct3_i != 3'b000) || (funct7_i != F7_BASE);
            default:    illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32_mc_ctrl.sv
// rtl/rv32_mc_ctrl.sv - multicycle control FSM for the RV32I core
module rv32_mc_ctrl
    import rv32_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        alu_flag,
    input  logic        alu_out_lsb,
    input  logic        mem_ready,
    output logic [3:0]  alu_cntrl,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        instr_retired,
    output logic        halt,
    output logic [1:0]  trap_cause
);

    // Counter only has to reach MEM_TIMEOUT-1; the trap fires on the wait cycle that hits it
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [1:0]    cause_q, cause_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] dec_alu;
    logic       dec_illegal;
    logic       is_system;
    logic       sys_ok;
    logic       is_load;
    logic       is_store;
    logic       mem_phase;
    logic       mem_wait;
    logic       timed_out;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    rv32_alu_op_decode u_alu_op_decode (
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .alu_cntrl_o (dec_alu),
        .illegal_o   (dec_illegal)
    );

    // Only the exact ECALL/EBREAK encodings are accepted under SYSTEM
    assign is_system = (opcode == OPC_SYSTEM);
    assign sys_ok    = ((instr[31:20] == 12'h000) || (instr[31:20] == 12'h001)) &&
                       (instr[19:7] == 13'h0000);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);

    // A request is outstanding in FETCH and MEM; any other cycle clears the wait count
    assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign mem_wait  = mem_phase && !mem_ready;
    assign timed_out = (MEM_TIMEOUT != 0) && mem_wait && (cnt_q == TO_LAST);
    assign cnt_d     = mem_wait ? cnt_q + TW'(1) : '0;

    // Next-state and Moore-style control decode; everything is held at zero during reset
    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        alu_cntrl     = ALU_ADDU;
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = SRC_B_RS2;
        imm_sel       = IMM_I;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = ADDR_PC;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_ALU;
        reg_write     = 1'b0;
        wb_sel        = WB_ALUOUT;
        instr_retired = 1'b0;
        halt          = 1'b0;
        trap_cause    = cause_q;

        case (state_q)
            ST_FETCH: begin
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_PC;
                alu_src_a    = SRC_A_PC;
                alu_src_b    = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MEM_TO;
                end
            end
            ST_DECODE: begin
                // Branch/jump target old_pc+imm is precomputed here into ALU-out
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_sel   = (opcode == OPC_JAL) ? IMM_J : IMM_B;
                if (dec_illegal || (is_system && !sys_ok)) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (is_system) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ECALL;
                end else if (opcode == OPC_FENCE) begin
                    instr_retired = 1'b1;
                    state_d       = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_cntrl = dec_alu;
                state_d   = ST_FETCH;
                case (opcode)
                    OPC_OP: begin
                        state_d = ST_WB;
                    end
                    OPC_OPIMM: begin
                        alu_src_b = SRC_B_IMM;
                        state_d   = ST_WB;
                    end
                    OPC_LUI: begin
                        alu_src_a = SRC_A_ZERO;
                        alu_src_b = SRC_B_IMM;
                        imm_sel   = IMM_U;
                        state_d   = ST_WB;
                    end
                    OPC_AUIPC: begin
                        alu_src_a = SRC_A_OLDPC;
                        alu_src_b = SRC_B_IMM;
                        imm_sel   = IMM_U;
                        state_d   = ST_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_src_b = SRC_B_IMM;
                        imm_sel   = is_store ? IMM_S : IMM_I;
                        state_d   = ST_MEM;
                    end
                    OPC_BRANCH: begin
                        imm_sel       = IMM_B;
                        instr_retired = 1'b1;
                        if (branch_taken(funct3, alu_flag, alu_out_lsb)) begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_ALUOUT;
                        end
                    end
                    OPC_JAL: begin
                        imm_sel       = IMM_J;
                        pc_write      = 1'b1;
                        pc_src        = PC_SRC_ALUOUT;
                        reg_write     = 1'b1;
                        wb_sel        = WB_PC;
                        instr_retired = 1'b1;
                    end
                    OPC_JALR: begin
                        alu_src_b     = SRC_B_IMM;
                        pc_write      = 1'b1;
                        pc_src        = PC_SRC_ALU;
                        reg_write     = 1'b1;
                        wb_sel        = WB_PC;
                        instr_retired = 1'b1;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_ALUOUT;
                mem_we       = is_store;
                if (mem_ready) begin
                    if (is_load) begin
                        state_d = ST_WB;
                    end else begin
                        instr_retired = 1'b1;
                        state_d       = ST_FETCH;
                    end
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MEM_TO;
                end
            end
            ST_WB: begin
                reg_write     = 1'b1;
                wb_sel        = is_load ? WB_MEM : WB_ALUOUT;
                instr_retired = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_TRAP: begin
                halt = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase

        if (rst) begin
            alu_cntrl     = 4'd0;
            alu_src_a     = 2'd0;
            alu_src_b     = 2'd0;
            imm_sel       = 3'd0;
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            mem_addr_sel  = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src        = 1'b0;
            reg_write     = 1'b0;
            wb_sel        = 2'd0;
            instr_retired = 1'b0;
            halt          = 1'b0;
            trap_cause    = 2'd0;
        end
    end

    // State, wait counter and trap cause registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// tb/tb_rv32_mc_ctrl.sv - directed self-checking bench for rv32_mc_ctrl
module tb_rv32_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        alu_flag;
    logic        alu_out_lsb;
    logic        mem_ready;
    logic [3:0]  alu_cntrl;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  imm_sel;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        instr_retired;
    logic        halt;
    logic [1:0]  trap_cause;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rv32_mc_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .alu_flag      (alu_flag),
        .alu_out_lsb   (alu_out_lsb),
        .mem_ready     (mem_ready),
        .alu_cntrl     (alu_cntrl),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_sel       (imm_sel),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr_sel  (mem_addr_sel),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .instr_retired (instr_retired),
        .halt          (halt),
        .trap_cause    (trap_cause)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait FETCH cycle, leaving the FSM in DECODE
    task automatic do_fetch(input logic [31:0] ins);
        instr     = ins;
        mem_ready = 1'b1;
        alu_flag  = 1'b0;
        alu_out_lsb = 1'b0;
        #1;
        chk("fetch_req", {31'd0, mem_req}, 32'd1);
        chk("fetch_irw_pcw", {30'd0, ir_write, pc_write}, 32'd3);
        chk("fetch_src", {28'd0, alu_src_a, alu_src_b}, {28'd0, 2'd1, 2'd1});
        tick();
        mem_ready = 1'b0;
    endtask

    // DECODE cycle, leaving the FSM in its successor
    task automatic do_decode(input logic [2:0] exp_imm);
        #1;
        chk("dec_alu_src", {24'd0, alu_cntrl, alu_src_a, alu_src_b}, {24'd0, 4'b0000, 2'd2, 2'd2});
        chk("dec_imm", {29'd0, imm_sel}, {29'd0, exp_imm});
        chk("dec_noreq", {31'd0, mem_req}, 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr = 32'd0; alu_flag = 1'b0; alu_out_lsb = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_outputs", {mem_req, ir_write, pc_write, reg_write, halt, trap_cause, instr_retired},
            32'd0);
        rst = 1'b0;

        // ADD: 4 cycles, retire in WB
        do_fetch(32'h002081B3);
        do_decode(3'd2);
        #1;
        chk("add_exec", {24'd0, alu_cntrl, alu_src_a, alu_src_b}, {24'd0, 4'b1000, 2'd0, 2'd0});
        chk("add_exec_noret", {30'd0, reg_write, instr_retired}, 32'd0);
        tick();
        #1;
        chk("add_wb", {28'd0, reg_write, wb_sel, instr_retired}, {28'd0, 1'b1, 2'd0, 1'b1});
        tick();

        // SUB
        do_fetch(32'h402081B3);
        do_decode(3'd2);
        #1;
        chk("sub_alu", {28'd0, alu_cntrl}, 32'h9);
        tick();
        #1;
        chk("sub_wb_ret", {31'd0, instr_retired}, 32'd1);
        tick();

        // SRAI
        do_fetch(32'h4030D093);
        do_decode(3'd2);
        #1;
        chk("srai_exec", {23'd0, alu_cntrl, alu_src_b, imm_sel}, {23'd0, 4'b1010, 2'd2, 3'd0});
        tick();
        #1;
        chk("srai_wb", {31'd0, reg_write}, 32'd1);
        tick();

        // BEQ taken
        do_fetch(32'h00208463);
        do_decode(3'd2);
        alu_flag = 1'b1;
        #1;
        chk("beq_t", {25'd0, alu_cntrl, pc_write, pc_src, instr_retired},
            {25'd0, 4'b1101, 1'b1, 1'b1, 1'b1});
        tick();
        alu_flag = 1'b0;

        // BEQ not taken
        do_fetch(32'h00208463);
        do_decode(3'd2);
        #1;
        chk("beq_nt", {30'd0, pc_write, instr_retired}, {30'd0, 1'b0, 1'b1});
        tick();

        // BLT taken via result LSB
        do_fetch(32'h0020C463);
        do_decode(3'd2);
        alu_out_lsb = 1'b1;
        #1;
        chk("blt_t", {26'd0, alu_cntrl, pc_write, pc_src}, {26'd0, 4'b1100, 1'b1, 1'b1});
        tick();
        alu_out_lsb = 1'b0;

        // JAL
        do_fetch(32'h0000006F);
        do_decode(3'd4);
        #1;
        chk("jal_exec", {27'd0, pc_write, pc_src, reg_write, wb_sel},
            {27'd0, 1'b1, 1'b1, 1'b1, 2'd2});
        tick();

        // FENCE retires from DECODE
        do_fetch(32'h0000000F);
        #1;
        chk("fence_ret", {30'd0, instr_retired, reg_write}, {30'd0, 1'b1, 1'b0});
        tick();

        // LW with three wait cycles in MEM
        do_fetch(32'h0000A183);
        do_decode(3'd2);
        #1;
        chk("lw_exec", {23'd0, alu_cntrl, alu_src_b, imm_sel}, {23'd0, 4'b0000, 2'd2, 3'd0});
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0;
            #1;
            chk("lw_mem_wait", {29'd0, mem_req, mem_addr_sel, mem_we}, {29'd0, 1'b1, 1'b1, 1'b0});
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_mem_ready", {30'd0, mem_req, mem_addr_sel}, {30'd0, 1'b1, 1'b1});
        tick();
        mem_ready = 1'b0;
        #1;
        chk("lw_wb", {28'd0, reg_write, wb_sel, instr_retired}, {28'd0, 1'b1, 2'd1, 1'b1});
        tick();

        // SW interrupted by reset mid-MEM
        do_fetch(32'h0020A023);
        do_decode(3'd2);
        #1;
        chk("sw_exec_imm", {29'd0, imm_sel}, 32'd1);
        tick();
        #1;
        chk("sw_mem", {30'd0, mem_req, mem_we}, {30'd0, 1'b1, 1'b1});
        tick();
        rst = 1'b1;
        #1;
        chk("sw_rst_drop", {31'd0, mem_req}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_fetch", {29'd0, mem_req, mem_addr_sel, halt}, {29'd0, 1'b1, 1'b0, 1'b0});

        // Memory timeout: this is wait cycle 1 of 4
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("to_wait_req", {30'd0, mem_req, halt}, {30'd0, 1'b1, 1'b0});
        end
        tick();
        #1;
        chk("to_trap", {28'd0, halt, trap_cause, mem_req}, {28'd0, 1'b1, 2'd3, 1'b0});

        // ECALL
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_fetch(32'h00000073);
        do_decode(3'd2);
        #1;
        chk("ecall_trap", {29'd0, halt, trap_cause}, {29'd0, 1'b1, 2'd2});
        tick();

        // Illegal instruction, then no further requests
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_fetch(32'hFFFFFFFF);
        do_decode(3'd2);
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            #1;
            chk("ill_trap", {28'd0, halt, trap_cause, mem_req}, {28'd0, 1'b1, 2'd1, 1'b0});
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
